// File: rtl/stochastic_stream_decoder.sv
// Counts the ones in each BIT_LENGTH-bit window of a stochastic bitstream and reports the decoded value.
// Define STOCH_DECODER_BIPOLAR_EN for bipolar decoding (2*ones - BIT_LENGTH); otherwise value is unipolar.
module stochastic_stream_decoder #(
    parameter int BIT_LENGTH = 128,
    parameter int CNT_W      = $clog2(BIT_LENGTH + 1),
    parameter int SIDX_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              bit_in,
    input  logic              bit_valid,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  ones_count,
    output logic [CNT_W:0]    value,
    output logic [SIDX_W-1:0] stream_idx
);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BIT_LENGTH - 1);
`ifdef STOCH_DECODER_BIPOLAR_EN
    localparam logic [CNT_W:0] BL_EXT = (CNT_W + 1)'(BIT_LENGTH);
`endif

    state_t              state_q;
    logic [CNT_W-1:0]    bit_cnt_q;
    logic [CNT_W-1:0]    ones_acc_q;
    logic                busy_q;
    logic                done_q;
    logic [CNT_W-1:0]    ones_count_q;
    logic [CNT_W:0]      value_q;
    logic [SIDX_W-1:0]   stream_idx_q;

    logic [CNT_W-1:0]    ones_total_d;
    logic [CNT_W:0]      value_d;

    // Totals including the current bit; only committed on the window's final bit.
    always_comb begin
        ones_total_d = ones_acc_q + CNT_W'(bit_in);
`ifdef STOCH_DECODER_BIPOLAR_EN
        // 2*ones never exceeds 2*BIT_LENGTH < 2^(CNT_W+1), so the subtraction wraps into a valid two's complement result.
        value_d = {ones_total_d, 1'b0} - BL_EXT;
`else
        value_d = {1'b0, ones_total_d};
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            ones_acc_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            ones_count_q <= '0;
            value_q      <= '0;
            stream_idx_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        bit_cnt_q  <= '0;
                        ones_acc_q <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (start) begin
                        bit_cnt_q  <= '0;
                        ones_acc_q <= '0;
                    end else if (bit_valid) begin
                        if (bit_cnt_q == LAST_IDX) begin
                            ones_count_q <= ones_total_d;
                            value_q      <= value_d;
                            stream_idx_q <= stream_idx_q + SIDX_W'(1);
                            busy_q       <= 1'b0;
                            done_q       <= 1'b1;
                            state_q      <= DONE;
                        end else begin
                            bit_cnt_q  <= bit_cnt_q + CNT_W'(1);
                            ones_acc_q <= ones_total_d;
                        end
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        bit_cnt_q  <= '0;
                        ones_acc_q <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= ACCUM;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign ones_count = ones_count_q;
    assign value      = value_q;
    assign stream_idx = stream_idx_q;

endmodule

// File: doc/stochastic_stream_decoder.md
Name: stochastic_stream_decoder

Overview:
- Converts serial stochastic bitstreams back to binary. This is the decoder end of the stochastic encode → arithmetic → decode path.
- Sits downstream of the stochastic adder/subtractor/multiplier blocks and replaces the offline software counting of output bitstreams.
- Accumulates exactly BIT_LENGTH valid bits per window, then reports the ones count and the decoded value with a one-cycle done pulse.

Parameters:
- BIT_LENGTH, 128, bits per stream window; must be ≥2.
- CNT_W, $clog2(BIT_LENGTH+1), width of ones_count; holds 0..BIT_LENGTH inclusive.
- SIDX_W, 16, width of the completed-stream index counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  opens a new window; also restarts a window in progress.
- bit_in  input  1  stochastic stream bit.
- bit_valid  input  1  bit_in is sampled when high and state is ACCUM.
- busy  output  1  high while in ACCUM.
- done  output  1  one-cycle pulse when a window completes.
- ones_count  output  CNT_W  number of 1s in the last completed window.
- value  output  CNT_W+1  signed decoded value (see Optional Feature).
- stream_idx  output  SIDX_W  count of completed windows; wraps modulo 2^SIDX_W.

Behaviour:
- Reset: state=IDLE; busy=0, done=0, ones_count=0, value=0, stream_idx=0; internal bit and ones counters cleared. Reset mid-window discards the partial window and produces no done.
- FSM states: IDLE, ACCUM, DONE.
- IDLE:
  - bit_valid is ignored.
  - start=1 → clear bit_cnt and ones_acc, go to ACCUM.
- ACCUM (busy=1):
  - start=1 has priority, including on the would-be final bit. It clears the counters, stays in ACCUM, and discards that cycle's bit; no done is produced.
  - Otherwise, when bit_valid=1: bit_cnt += 1 and ones_acc += bit_in.
  - When bit_cnt == BIT_LENGTH-1 with bit_valid=1 and start=0: the final bit is included and the state goes to DONE.
  - Gaps in bit_valid only stall the window; they do not abort it.
- DONE (exactly one cycle):
  - done=1, and ones_count/value hold the final totals. Outputs are registered: done asserts the cycle after the last bit is accepted (latency 1).
  - stream_idx increments by 1 (wrapping) in the same cycle done is high.
  - bit_valid is ignored.
  - start=1 → clear counters and go directly to ACCUM (back-to-back windows). Otherwise → IDLE.
- ones_count and value hold their last values until the next DONE; they do not change during accumulation.
- Arithmetic:
  - ones_acc is CNT_W bits and never exceeds BIT_LENGTH.
  - Bipolar value = 2*ones − BIT_LENGTH, computed in CNT_W+1-bit two's complement. Range is −BIT_LENGTH..+BIT_LENGTH, so no overflow occurs.

Optional Feature:
- Macro: STOCH_DECODER_BIPOLAR_EN.
- Defined: value = 2*ones_count − BIT_LENGTH (bipolar encoding, matching the subtractor's signed output).
- Undefined: value = ones_count zero-extended to CNT_W+1 (unipolar encoding). All other behaviour is identical.

Test Plan:
- Reset, pulse start, 128 consecutive bit_valid=1 with bit_in=1 → one cycle later done=1, ones_count=128, value=+128 (bipolar) / 128 (unipolar), stream_idx=1.
- start, 128 bits alternating 1,0 → ones_count=64, bipolar value=0. Next window of all 0s started in the DONE cycle → back-to-back, second done gives ones_count=0, value=−128, stream_idx=2.
- start, feed 128 ones with bit_valid low on every third cycle → done exactly once, after the 128th accepted bit, with ones_count=128. busy stays 1 throughout the gaps.
- start, 50 ones, assert start again, then 128 zeros → no done after the first 50 bits; a single done with ones_count=0.
- start, 100 ones, then rst for 1 cycle → all outputs 0, state IDLE. Subsequent bit_valid without start → no done, counters unchanged.
- Drive 3 windows with 96, 32 and 128 ones → bipolar values +64, −64, +128 in order. stream_idx=3; ones_count/value stay stable between done pulses.
